// File: rtl/kernel_mem_bridge.sv
// Kernel-to-unified-memory bridge: queues kernel read/write beats in a small
// command FIFO, meters read credit and forwards read data one cycle later.
module kernel_mem_bridge #(
   parameter int unsigned ADDR_WIDTH      = 29,
   parameter int unsigned DATA_WIDTH      = 512,
   parameter int unsigned BURST_WIDTH     = 7,
   parameter int unsigned CMD_DEPTH       = 4,
   parameter int unsigned MAX_OUTSTANDING = 64
) (
   input  logic                                clk,
   input  logic                                rstn,
   // kernel side
   input  logic [ADDR_WIDTH+5:0]               s_address,
   input  logic                                s_read,
   input  logic                                s_write,
   input  logic [DATA_WIDTH-1:0]               s_writedata,
   input  logic [DATA_WIDTH/8-1:0]             s_byteenable,
   input  logic [3:0]                          s_burstcount,
   output logic                                s_waitrequest,
   output logic [DATA_WIDTH-1:0]               s_readdata,
   output logic                                s_readdatavalid,
   // memory side
   output logic [ADDR_WIDTH-1:0]               m_address,
   output logic                                m_read,
   output logic                                m_write,
   output logic [DATA_WIDTH-1:0]               m_writedata,
   output logic [DATA_WIDTH/8-1:0]             m_byteenable,
   output logic [BURST_WIDTH-1:0]              m_burstcount,
   input  logic                                m_waitrequest,
   input  logic [DATA_WIDTH-1:0]               m_readdata,
   input  logic                                m_readdatavalid,
   // status
   output logic                                busy,
   output logic [$clog2(MAX_OUTSTANDING):0]    outstanding
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned PTR_WIDTH = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned CNT_WIDTH = $clog2(CMD_DEPTH) + 1;

   typedef struct packed {
      logic                   is_write;
      logic [ADDR_WIDTH-1:0]  address;
      logic [BURST_WIDTH-1:0] burstcount;
      logic [DATA_WIDTH-1:0]  data;
      logic [BE_WIDTH-1:0]    byteenable;
   } cmd_t;

   typedef enum logic {
      IDLE,
      WR_BURST
   } wr_state_t;

   wr_state_t              state, state_nxt;
   logic [3:0]             beats_left, beats_left_nxt;

   cmd_t                   mem [CMD_DEPTH];
   cmd_t                   push_cmd;
   cmd_t                   head;
   logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
   logic [CNT_WIDTH-1:0]   count;
   logic                   fifo_full, fifo_empty;
   logic                   push, pop;

   logic [3:0]             burst_eff;
   logic                   is_rd;
   logic [OUT_WIDTH:0]     credit_sum;
   logic                   credit_over;
   logic                   rd_accept, rdv_take;
   logic [OUT_WIDTH-1:0]   outstanding_nxt;
   logic                   unused_addr_bits;

   // Burst of zero is a single beat
   assign burst_eff   = (s_burstcount == 4'd0) ? 4'd1 : s_burstcount;
   assign is_rd       = s_read & ~s_write;
   assign credit_sum  = {1'b0, outstanding} + (OUT_WIDTH+1)'(burst_eff);
   assign credit_over = credit_sum > (OUT_WIDTH+1)'(MAX_OUTSTANDING);

   assign fifo_full   = (count == CNT_WIDTH'(CMD_DEPTH));
   assign fifo_empty  = (count == CNT_WIDTH'(0));

   assign s_waitrequest = fifo_full | ((state == WR_BURST) & ~s_write) | (is_rd & credit_over);
   assign push          = (s_read | s_write) & ~s_waitrequest;
   assign pop           = ~fifo_empty & ~m_waitrequest;

   assign unused_addr_bits = ^s_address[5:0];

   assign push_cmd.is_write   = s_write;
   assign push_cmd.address    = s_address[ADDR_WIDTH+5:6];
   assign push_cmd.burstcount = BURST_WIDTH'(burst_eff);
   assign push_cmd.data       = s_writedata;
   assign push_cmd.byteenable = s_byteenable;

   // Command storage; contents are only observed through the non-empty gate below
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_cmd;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= PTR_WIDTH'(0);
         rd_ptr <= PTR_WIDTH'(0);
         count  <= CNT_WIDTH'(0);
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_WIDTH'(1);
            2'b01:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   assign head         = mem[rd_ptr];
   assign m_read       = ~fifo_empty & ~head.is_write;
   assign m_write      = ~fifo_empty & head.is_write;
   assign m_address    = fifo_empty ? '0 : head.address;
   assign m_burstcount = fifo_empty ? '0 : head.burstcount;
   assign m_writedata  = fifo_empty ? '0 : head.data;
   assign m_byteenable = fifo_empty ? '0 : head.byteenable;

   // Write-burst tracker
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         beats_left <= 4'd0;
      end else begin
         state      <= state_nxt;
         beats_left <= beats_left_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      beats_left_nxt = beats_left;
      case (state)
         IDLE: begin
            if (push && s_write && (burst_eff > 4'd1)) begin
               state_nxt      = WR_BURST;
               beats_left_nxt = burst_eff - 4'd1;
            end
         end
         WR_BURST: begin
            if (push && s_write) begin
               beats_left_nxt = beats_left - 4'd1;
               if (beats_left == 4'd1) state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt      = IDLE;
            beats_left_nxt = 4'd0;
         end
      endcase
   end

   // Read credit: a return with nothing reserved is a stray and is dropped
   assign rd_accept = push & is_rd;
   assign rdv_take  = m_readdatavalid & (outstanding != OUT_WIDTH'(0));
   assign outstanding_nxt = outstanding
                          + (rd_accept ? OUT_WIDTH'(burst_eff) : OUT_WIDTH'(0))
                          - (rdv_take  ? OUT_WIDTH'(1)         : OUT_WIDTH'(0));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding     <= OUT_WIDTH'(0);
         s_readdatavalid <= 1'b0;
         s_readdata      <= '0;
      end else begin
         outstanding     <= outstanding_nxt;
         s_readdatavalid <= rdv_take;
         if (rdv_take) s_readdata <= m_readdata;
      end
   end

   assign busy = ~fifo_empty | (outstanding != OUT_WIDTH'(0)) | (state == WR_BURST) | s_readdatavalid;

endmodule
